serial_rx_fifo: RTL and testbench
=================================

Name: serial_rx_fifo

Overview:
Byte FIFO sitting directly downstream of serial_rx. It captures every o_wr/o_data strobe from the receiver and buffers it, so the consumer (uFork core I/O port or host-link logic) can drain characters at its own pace. It is first-word-fall-through, reports occupancy and an almost-full level for flow control, and flags overrun with a sticky error bit when a byte arrives while full.

Parameters:
DEPTH, 16, number of byte entries; power of two, minimum 2
DATA_WIDTH, 8, bits per entry; matches serial_rx o_data
AFULL_LEVEL, 12, o_afull asserts when occupancy >= this value; range 1..DEPTH

Ports:
i_clk  input  1  system clock; all logic on posedge
i_rst_n  input  1  asynchronous active-low reset
i_wr  input  1  write strobe, one cycle per byte (from serial_rx o_wr)
i_data  input  DATA_WIDTH  byte to store, valid when i_wr=1 (from serial_rx o_data)
i_rd  input  1  pop head entry; only honoured when o_valid=1
o_valid  output  1  FIFO non-empty; o_data holds head byte
o_data  output  DATA_WIDTH  head byte (FWFT); all zeros when o_valid=0
o_count  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH
o_full  output  1  occupancy == DEPTH
o_afull  output  1  occupancy >= AFULL_LEVEL
o_overrun  output  1  sticky: a write was dropped because FIFO full
i_clr_overrun  input  1  synchronous clear of o_overrun

Behaviour:
- Reset (i_rst_n=0, async, takes effect immediately): wr_ptr=0, rd_ptr=0, count=0, o_overrun=0 -> o_valid=0, o_data=0, o_count=0, o_full=0, o_afull=0. Storage array is not reset.
- Pointers are $clog2(DEPTH) bits and wrap naturally from DEPTH-1 to 0. Occupancy is held in a dedicated count register (width $clog2(DEPTH)+1), not derived from pointers.
- Write accepted when i_wr=1 and (count<DEPTH, or count==DEPTH with a simultaneous accepted read): mem[wr_ptr]<=i_data, wr_ptr+1.
- Read accepted when i_rd=1 and count>0: rd_ptr+1. i_rd while empty is ignored with no side effects.
- Count update: +1 on write only, -1 on read only, unchanged when both are accepted or neither is.
- Empty with simultaneous i_wr and i_rd: the write is accepted and the read ignored, so count becomes 1.
- Full with i_wr and no accepted read: the byte is dropped, the array and pointers are unchanged, and o_overrun<=1.
- Full with i_wr and an accepted read: both succeed, count stays DEPTH, and no overrun is flagged.
- o_overrun stays set until i_clr_overrun=1. If a new overrun coincides with the clear, set wins.
- Latency: a byte written at edge N is visible as o_valid=1 and o_data=byte in the cycle after edge N. After a pop at edge N, the next entry (or o_valid=0) appears after edge N.
- o_valid, o_full and o_afull are decoded from the registered count. o_data = o_valid ? mem[rd_ptr] : 0 (combinational read of the head).
- An async reset mid-stream discards all buffered bytes and the overrun flag. The first write after reset deassertion lands in entry 0.

Test Plan:
- Reset: hold i_rst_n=0 mid-operation with count=5 -> o_count=0, o_valid=0, o_data=8'h00, o_overrun=0 immediately, without waiting for a clock edge.
- Single byte: i_wr pulse with 8'h4B ("K"), as from serial_rx -> next cycle o_valid=1, o_data=8'h4B, o_count=1. Then i_rd for one cycle -> o_valid=0, o_data=0, o_count=0.
- Fill/order (DEPTH=4, AFULL_LEVEL=3): write 8'h01..8'h04 -> o_afull=1 after the 3rd write, o_full=1 after the 4th. Read all four -> bytes come out as 01,02,03,04 and pointers wrap. Repeat with 8'h05..8'h08 to check wrap-around ordering.
- Overrun: with the FIFO full, write 8'hEE -> o_overrun=1, head still 8'h01, count 4. Pulse i_clr_overrun -> o_overrun=0. In a separate case, clear and overrun in the same cycle -> o_overrun remains 1.
- Simultaneous read/write when full: i_wr=8'h09 and i_rd together -> o_overrun stays 0, count stays 4, and the 8'h09 byte is read last.
- Simultaneous read/write when empty: i_wr=8'h33 and i_rd together -> count=1, o_data=8'h33. Also, i_rd alone while empty -> no change.

Source files
------------

// File: rtl/serial_rx_fifo.sv
// First-word-fall-through byte FIFO behind serial_rx. It reports occupancy and almost-full,
// and holds a sticky overrun flag for bytes dropped while the FIFO is full.
module serial_rx_fifo #(
    parameter int unsigned DEPTH       = 16,
    parameter int unsigned DATA_WIDTH  = 8,
    parameter int unsigned AFULL_LEVEL = 12
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic                    i_wr,
    input  logic [DATA_WIDTH-1:0]   i_data,
    input  logic                    i_rd,
    input  logic                    i_clr_overrun,
    output logic                    o_valid,
    output logic [DATA_WIDTH-1:0]   o_data,
    output logic [$clog2(DEPTH):0]  o_count,
    output logic                    o_full,
    output logic                    o_afull,
    output logic                    o_overrun
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [PtrW-1:0]       wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]       rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]       count_q, count_d;
    logic                  overrun_q, overrun_d;
    logic                  wr_ok, rd_ok, full;

    assign full  = (count_q == CntW'(DEPTH));
    assign rd_ok = i_rd && (count_q != '0);
    // A full FIFO still accepts a write when the head is popped in the same cycle.
    assign wr_ok = i_wr && (!full || rd_ok);

    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        overrun_d = overrun_q;
        if (wr_ok) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (rd_ok) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (wr_ok && !rd_ok) begin
            count_d = count_q + 1'b1;
        end else if (rd_ok && !wr_ok) begin
            count_d = count_q - 1'b1;
        end
        // A new drop takes priority over a coincident clear.
        if (i_wr && !wr_ok) begin
            overrun_d = 1'b1;
        end else if (i_clr_overrun) begin
            overrun_d = 1'b0;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            overrun_q <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            overrun_q <= overrun_d;
        end
    end

    always_ff @(posedge i_clk) begin
        if (wr_ok) begin
            mem_q[wr_ptr_q] <= i_data;
        end
    end

    assign o_valid   = (count_q != '0);
    assign o_data    = o_valid ? mem_q[rd_ptr_q] : '0;
    assign o_count   = count_q;
    assign o_full    = full;
    assign o_afull   = (count_q >= CntW'(AFULL_LEVEL));
    assign o_overrun = overrun_q;

endmodule

// File: tb/tb_serial_rx_fifo.sv
// Directed, table-driven bench for serial_rx_fifo at DEPTH=4, AFULL_LEVEL=3.
module tb_serial_rx_fifo;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned AFL   = 3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       wr = 1'b0, rd = 1'b0, clr = 1'b0;
    logic [7:0] wdata = '0;
    logic       valid, full, afull, overrun;
    logic [7:0] rdata;
    logic [2:0] count;

    int n_checks = 0;
    int n_pass   = 0;

    serial_rx_fifo #(
        .DEPTH       (DEPTH),
        .DATA_WIDTH  (8),
        .AFULL_LEVEL (AFL)
    ) dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_wr          (wr),
        .i_data        (wdata),
        .i_rd          (rd),
        .i_clr_overrun (clr),
        .o_valid       (valid),
        .o_data        (rdata),
        .o_count       (count),
        .o_full        (full),
        .o_afull       (afull),
        .o_overrun     (overrun)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       wr;
        logic [7:0] data;
        logic       rd;
        logic       clr;
        logic       valid;
        logic [7:0] rdata;
        logic [2:0] count;
        logic       full;
        logic       afull;
        logic       overrun;
    } vec_t;

    vec_t vq[$];

    task automatic chk(input string name, input int unsigned act, input int unsigned exp);
        n_checks++;
        if (act == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic v, input logic [7:0] d,
                           input logic [2:0] c, input logic f, input logic a, input logic o);
        chk({tag, " valid"}, valid, v);
        chk({tag, " data"}, rdata, d);
        chk({tag, " count"}, count, c);
        chk({tag, " full"}, full, f);
        chk({tag, " afull"}, afull, a);
        chk({tag, " overrun"}, overrun, o);
    endtask

    // Drive one cycle of inputs at the falling edge, sample 1 time unit after the rising edge.
    task automatic step(input logic w, input logic [7:0] d, input logic r, input logic c);
        @(negedge clk);
        wr = w; wdata = d; rd = r; clr = c;
        @(posedge clk);
        #1;
        wr = 1'b0; rd = 1'b0; clr = 1'b0; wdata = '0;
    endtask

    initial begin
        //                 wr    data   rd    clr   valid rdata  cnt   full  afull ovr
        vq.push_back(vec_t'{1'b1, 8'h4B, 1'b0, 1'b0, 1'b1, 8'h4B, 3'd1, 1'b0, 1'b0, 1'b0});
        vq.push_back(vec_t'{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0, 1'b0});
        vq.push_back(vec_t'{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0, 1'b0});
        vq.push_back(vec_t'{1'b1, 8'h33, 1'b1, 1'b0, 1'b1, 8'h33, 3'd1, 1'b0, 1'b0, 1'b0});
        vq.push_back(vec_t'{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0, 1'b0});
        vq.push_back(vec_t'{1'b1, 8'h01, 1'b0, 1'b0, 1'b1, 8'h01, 3'd1, 1'b0, 1'b0, 1'b0});
        vq.push_back(vec_t'{1'b1, 8'h02, 1'b0, 1'b0, 1'b1, 8'h01, 3'd2, 1'b0, 1'b0, 1'b0});
        vq.push_back(vec_t'{1'b1, 8'h03, 1'b0, 1'b0, 1'b1, 8'h01, 3'd3, 1'b0, 1'b1, 1'b0});
        vq.push_back(vec_t'{1'b1, 8'h04, 1'b0, 1'b0, 1'b1, 8'h01, 3'd4, 1'b1, 1'b1, 1'b0});
        vq.push_back(vec_t'{1'b1, 8'hEE, 1'b0, 1'b0, 1'b1, 8'h01, 3'd4, 1'b1, 1'b1, 1'b1});
        vq.push_back(vec_t'{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 8'h01, 3'd4, 1'b1, 1'b1, 1'b0});
        vq.push_back(vec_t'{1'b1, 8'h09, 1'b1, 1'b0, 1'b1, 8'h02, 3'd4, 1'b1, 1'b1, 1'b0});
        vq.push_back(vec_t'{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h03, 3'd3, 1'b0, 1'b1, 1'b0});
        vq.push_back(vec_t'{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h04, 3'd2, 1'b0, 1'b0, 1'b0});
        vq.push_back(vec_t'{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h09, 3'd1, 1'b0, 1'b0, 1'b0});
        vq.push_back(vec_t'{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0, 1'b0});
        vq.push_back(vec_t'{1'b1, 8'h05, 1'b0, 1'b0, 1'b1, 8'h05, 3'd1, 1'b0, 1'b0, 1'b0});
        vq.push_back(vec_t'{1'b1, 8'h06, 1'b0, 1'b0, 1'b1, 8'h05, 3'd2, 1'b0, 1'b0, 1'b0});
        vq.push_back(vec_t'{1'b1, 8'h07, 1'b0, 1'b0, 1'b1, 8'h05, 3'd3, 1'b0, 1'b1, 1'b0});
        vq.push_back(vec_t'{1'b1, 8'h08, 1'b0, 1'b0, 1'b1, 8'h05, 3'd4, 1'b1, 1'b1, 1'b0});
        // Overrun and clear in the same cycle: the set must win.
        vq.push_back(vec_t'{1'b1, 8'hEE, 1'b0, 1'b1, 1'b1, 8'h05, 3'd4, 1'b1, 1'b1, 1'b1});
        vq.push_back(vec_t'{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h06, 3'd3, 1'b0, 1'b1, 1'b1});
        vq.push_back(vec_t'{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h07, 3'd2, 1'b0, 1'b0, 1'b1});
        vq.push_back(vec_t'{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h08, 3'd1, 1'b0, 1'b0, 1'b1});
        vq.push_back(vec_t'{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0, 1'b1});
        vq.push_back(vec_t'{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0, 1'b0});

        // Reset state before any clock edge.
        #2;
        chk_all("reset", 1'b0, 8'h00, 3'd0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < vq.size(); i++) begin
            step(vq[i].wr, vq[i].data, vq[i].rd, vq[i].clr);
            chk_all($sformatf("vec%0d", i), vq[i].valid, vq[i].rdata, vq[i].count,
                    vq[i].full, vq[i].afull, vq[i].overrun);
        end

        // Mid-stream async reset with the FIFO full and overrun set.
        step(1'b1, 8'hA1, 1'b0, 1'b0);
        step(1'b1, 8'hA2, 1'b0, 1'b0);
        step(1'b1, 8'hA3, 1'b0, 1'b0);
        step(1'b1, 8'hA4, 1'b0, 1'b0);
        step(1'b1, 8'hEE, 1'b0, 1'b0);
        chk_all("pre_rst", 1'b1, 8'hA1, 3'd4, 1'b1, 1'b1, 1'b1);
        #1;
        rst_n = 1'b0;
        #1;
        chk_all("async_rst", 1'b0, 8'h00, 3'd0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        // Post-reset: old contents discarded, new bytes come out in order.
        step(1'b1, 8'h5A, 1'b0, 1'b0);
        chk_all("post_rst_wr", 1'b1, 8'h5A, 3'd1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'h6B, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        chk_all("post_rst_rd", 1'b1, 8'h6B, 3'd1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        chk_all("post_rst_empty", 1'b0, 8'h00, 3'd0, 1'b0, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
